mem_io_controller: RTL

//  Parametrised successor of the fixed memory/LED controller. It sits between the CPU data port
//  and the board, and gives the CPU three things:
//  - a byte-enable data RAM;
//  - NUM_OUT_CH output register channels, each written with write/set/clear/toggle ops;
//  - a free-running cycle counter.

---
 rtl/mem_io_pkg.sv | 24 ++
 rtl/mem_io_controller_byte_en_ram.sv | 33 +++
 rtl/mem_io_controller.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_io_pkg.sv
// Shared types and constants for the memory/IO controller.
package mem_io_pkg;

    typedef enum logic {
        REGION_RAM = 1'b0,
        REGION_IO  = 1'b1
    } region_e;

    typedef enum logic [1:0] {
        IO_WRITE  = 2'd0,
        IO_SET    = 2'd1,
        IO_CLEAR  = 2'd2,
        IO_TOGGLE = 2'd3
    } io_op_e;

    localparam int IO_IDX_W = 6;
    localparam int CNT_W    = 32;

    // The cycle counter sits directly after the last channel op address.
    function automatic logic io_is_counter(input logic [IO_IDX_W-1:0] idx, input int nch);
        return int'(idx) == 4 * nch;
    endfunction

endpackage

// File: rtl/mem_io_controller_byte_en_ram.sv
// Single-port-per-direction data RAM: synchronous read with enable, per-byte write.
// A read and write to the same word at the same edge returns the old word.
module byte_en_ram #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rd_en,
    input  logic [$clog2(DEPTH)-1:0]  rd_addr,
    output logic [DATA_W-1:0]         rd_data,
    input  logic                      wr_en,
    input  logic [$clog2(DEPTH)-1:0]  wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic [DATA_W/8-1:0]       wr_be
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read port holds its output between enabled reads; array is never reset.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
        if (wr_en) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/mem_io_controller.sv
// CPU-facing controller: byte-enable RAM, output channel registers with
// write/set/clear/toggle ops, free-running cycle counter, pipelined reads.
module mem_io_controller
    import mem_io_pkg::*;
#(
    parameter int               ADDR_W     = 16,
    parameter int               DATA_W     = 32,
    parameter int               RAM_DEPTH  = 1024,
    parameter int               NUM_OUT_CH = 2,
    parameter int               OUT_W      = 18,
    parameter logic [OUT_W-1:0] OUT_RST    = '0,
    parameter int               RD_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rd_req,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic                         rd_valid,
    output logic [DATA_W-1:0]            rd_data,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic [DATA_W/8-1:0]          wr_be,
    output logic [NUM_OUT_CH*OUT_W-1:0]  out_ch
);

    localparam int RAM_AW   = $clog2(RAM_DEPTH);
    localparam int IO_MAP   = 4 * NUM_OUT_CH;
    localparam int CNT_RD_W = (CNT_W < DATA_W) ? CNT_W : DATA_W;

    region_e               rd_region;
    region_e               wr_region;
    logic [IO_IDX_W-1:0]   rd_idx;
    logic [IO_IDX_W-1:0]   wr_idx;
    logic                  wr_io_ch;
    logic [OUT_W-1:0]      ch_q [NUM_OUT_CH];
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_W-1:0]     ram_q;
    logic [DATA_W-1:0]     io_rd_val;
    logic                  valid1;
    logic                  sel_io1;
    logic [DATA_W-1:0]     io_q1;
    logic [DATA_W-1:0]     stage1_data;
    logic                  unused_addr_bits;

    assign rd_region = region_e'(rd_addr[ADDR_W-1]);
    assign wr_region = region_e'(wr_addr[ADDR_W-1]);
    assign rd_idx    = rd_addr[IO_IDX_W-1:0];
    assign wr_idx    = wr_addr[IO_IDX_W-1:0];
    assign wr_io_ch  = wr_en && (wr_region == REGION_IO) && (int'(wr_idx) < IO_MAP);
    // Upper in-region address bits alias by design.
    assign unused_addr_bits = ^{rd_addr, wr_addr};

    function automatic logic [OUT_W-1:0] apply_op(input io_op_e op,
                                                  input logic [OUT_W-1:0] cur,
                                                  input logic [OUT_W-1:0] d);
        case (op)
            IO_WRITE:  return d;
            IO_SET:    return cur | d;
            IO_CLEAR:  return cur & ~d;
            default:   return cur ^ d;
        endcase
    endfunction

    // Writes during reset are dropped so the RAM only changes on real transactions.
    byte_en_ram #(
        .DEPTH  (RAM_DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .rd_en   (rd_req && (rd_region == REGION_RAM)),
        .rd_addr (rd_addr[RAM_AW-1:0]),
        .rd_data (ram_q),
        .wr_en   (wr_en && !rst && (wr_region == REGION_RAM)),
        .wr_addr (wr_addr[RAM_AW-1:0]),
        .wr_data (wr_data),
        .wr_be   (wr_be)
    );

    // Channel registers: the op is chosen by the low two address bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_OUT_CH; c++) begin
                ch_q[c] <= OUT_RST;
            end
        end else if (wr_io_ch) begin
            for (int c = 0; c < NUM_OUT_CH; c++) begin
                if (int'(wr_idx[IO_IDX_W-1:2]) == c) begin
                    ch_q[c] <= apply_op(io_op_e'(wr_idx[1:0]), ch_q[c], wr_data[OUT_W-1:0]);
                end
            end
        end
    end

    // Free-running cycle counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // IO read mux; sampled before this edge's write so reads see the old value.
    always_comb begin
        io_rd_val = '0;
        if (int'(rd_idx) < IO_MAP) begin
            for (int c = 0; c < NUM_OUT_CH; c++) begin
                if (int'(rd_idx[IO_IDX_W-1:2]) == c) begin
                    io_rd_val[OUT_W-1:0] = ch_q[c];
                end
            end
        end else if (io_is_counter(rd_idx, NUM_OUT_CH)) begin
            io_rd_val[CNT_RD_W-1:0] = cnt_q[CNT_RD_W-1:0];
        end
    end

    // First read stage; resetting to the IO path with zero data makes rd_data read 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid1  <= 1'b0;
            sel_io1 <= 1'b1;
            io_q1   <= '0;
        end else begin
            valid1 <= rd_req;
            if (rd_req) begin
                sel_io1 <= (rd_region == REGION_IO);
                io_q1   <= io_rd_val;
            end
        end
    end

    assign stage1_data = sel_io1 ? io_q1 : ram_q;

    // Qualifying rd_valid with rst drops a read that would land in a reset cycle.
    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic              valid2;
            logic [DATA_W-1:0] data2;

            // Optional output register stage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid2 <= 1'b0;
                    data2  <= '0;
                end else begin
                    valid2 <= valid1;
                    if (valid1) begin
                        data2 <= stage1_data;
                    end
                end
            end

            assign rd_valid = valid2 & ~rst;
            assign rd_data  = data2;
        end else begin : g_lat1
            assign rd_valid = valid1 & ~rst;
            assign rd_data  = stage1_data;
        end
    endgenerate

    // Flatten channel registers onto the output bus.
    always_comb begin
        out_ch = '0;
        for (int c = 0; c < NUM_OUT_CH; c++) begin
            out_ch[c*OUT_W +: OUT_W] = ch_q[c];
        end
    end

endmodule
